// File: rtl/acc_pkg.sv
// Shared types and helpers for the product accumulator.
// Build option: define ACC_SAT_EN for saturating arithmetic (default wraps).
package acc_pkg;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    localparam int unsigned MAX_W = 64;

    // Replicates bit w-1 of v into all higher bits; callers truncate to width.
    function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [MAX_W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i >= w) r[i] = v[w-1];
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] sat_max(input int unsigned aw);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < aw - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int unsigned aw);
        logic [MAX_W-1:0] r;
        r = '1;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < aw - 1) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_sat_add.sv
// AW-bit signed adder with overflow detect.
// Build option: ACC_SAT_EN clamps the sum to the signed range on overflow.
module acc_sat_add
    import acc_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          overflow
);

`ifdef ACC_SAT_EN
    localparam logic [AW-1:0] SAT_POS = AW'(sat_max(AW));
    localparam logic [AW-1:0] SAT_NEG = AW'(sat_min(AW));
`endif

    logic [AW-1:0] raw;

    always_comb begin
        raw      = a + b;
        overflow = (a[AW-1] == b[AW-1]) && (raw[AW-1] != a[AW-1]);
`ifdef ACC_SAT_EN
        // Overflow direction follows the (shared) operand sign.
        sum = overflow ? (a[AW-1] ? SAT_NEG : SAT_POS) : raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums N consecutive signed products into one frame result with overflow flag.
// Build option: ACC_SAT_EN selects saturating instead of wrapping arithmetic.
module product_accumulator
    import acc_pkg::*;
#(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int N  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PW-1:0]        p_in,
    input  logic                 p_valid,
    output logic                 p_ready,
    input  logic                 clear,
    output logic [AW-1:0]        sum_out,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 overflow,
    output logic [$clog2(N)-1:0] cnt
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [AW-1:0] acc;
    logic          sticky;
    logic [AW-1:0] p_ext;
    logic [AW-1:0] add_sum;
    logic          add_ovf;
    logic          accept;

    assign p_ready = (state == ACCUM) || (state == HOLD && sum_ready);
    assign accept  = p_valid && p_ready;
    assign p_ext   = AW'(sign_extend(MAX_W'(p_in), PW));

    // acc is zero while in HOLD, so a product accepted on the release edge starts a new frame.
    acc_sat_add #(.AW(AW)) u_add (
        .a        (acc),
        .b        (p_ext),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            sum_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (state == HOLD && sum_ready) begin
                state     <= ACCUM;
                sum_valid <= 1'b0;
            end
            if (accept) begin
                if (cnt == LAST) begin
                    sum_out   <= add_sum;
                    overflow  <= sticky | add_ovf;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    sticky    <= 1'b0;
                    state     <= HOLD;
                end else begin
                    acc    <= add_sum;
                    cnt    <= cnt + 1'b1;
                    sticky <= sticky | add_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (table, directed and random stimulus vs. a reference model).
module tb_product_accumulator;

    localparam int PW = 16;
    localparam int AW = 24;
    localparam int N  = 8;
    localparam int CW = $clog2(N);

    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] p_in;
    logic          p_valid, clear, sum_ready;
    logic          p_ready, sum_valid, overflow;
    logic [AW-1:0] sum_out;
    logic [CW-1:0] cnt;

    logic          p_ready18, sum_valid18, overflow18;
    logic [17:0]   sum_out18;
    logic [CW-1:0] cnt18;

    product_accumulator #(.PW(PW), .AW(AW), .N(N)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready),
        .clear(clear), .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .overflow(overflow), .cnt(cnt)
    );

    product_accumulator #(.PW(PW), .AW(18), .N(N)) dut18 (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready18),
        .clear(clear), .sum_out(sum_out18), .sum_valid(sum_valid18), .sum_ready(sum_ready),
        .overflow(overflow18), .cnt(cnt18)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: frame-level arithmetic on plain integers.
    longint m_acc, m_sum;
    int     m_cnt;
    bit     m_sticky, m_hold, m_valid, m_ovf;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint wrap(input longint t);
        longint m;
        m = t & ((longint'(1) <<< AW) - 1);
        if (m > MAXV) m = m - (longint'(1) <<< AW);
        return m;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_sum = 0; m_cnt = 0;
        m_sticky = 0; m_hold = 0; m_valid = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit v, input longint p, input bit sr, input bit clr);
        longint t, r;
        bit o, rdy;
        rdy = !m_hold || sr;
        if (clr) begin
            m_hold = 0; m_acc = 0; m_cnt = 0; m_sticky = 0; m_valid = 0; m_ovf = 0;
        end else begin
            if (m_hold && sr) begin
                m_hold = 0; m_valid = 0;
            end
            if (v && rdy) begin
                t = m_acc + p;
                o = (t > MAXV) || (t < MINV);
`ifdef ACC_SAT_EN
                r = (t > MAXV) ? MAXV : (t < MINV) ? MINV : t;
`else
                r = wrap(t);
`endif
                if (m_cnt == N - 1) begin
                    m_sum = r; m_ovf = m_sticky | o; m_valid = 1; m_hold = 1;
                    m_acc = 0; m_cnt = 0; m_sticky = 0;
                end else begin
                    m_acc = r; m_cnt++; m_sticky = m_sticky | o;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("cnt", longint'(cnt), longint'(m_cnt));
        check("sum_valid", longint'(sum_valid), longint'(m_valid));
        check("sum_out", longint'($signed(sum_out)), m_sum);
        check("overflow", longint'(overflow), longint'(m_ovf));
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input bit v, input logic [PW-1:0] p, input bit sr, input bit clr,
                         output bit accepted);
        p_valid = v; p_in = p; sum_ready = sr; clear = clr;
        #1;
        check("p_ready", longint'(p_ready), longint'(!m_hold || sr));
        accepted = v && (!m_hold || sr) && !clr;
        @(posedge clk);
        model_step(v, longint'($signed(p)), sr, clr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [PW-1:0] p, input bit sr);
        bit a;
        int tries;
        tries = 0;
        a = 0;
        while (!a && tries < 50) begin
            cycle(1'b1, p, sr, 1'b0, a);
            tries++;
        end
        if (!a) begin
            checks++;
            $display("FAIL send_timeout: product %0d not accepted within %0d cycles", $signed(p), tries);
        end
    endtask

    task automatic send_frame(input logic [PW-1:0] p, input bit sr);
        for (int j = 0; j < N; j++) send(p, sr);
    endtask

    typedef struct {
        logic [PW-1:0] p[N];
        longint        exp_sum;
        bit            exp_ovf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit a;
        int hold_acc;

        for (int j = 0; j < N; j++) tbl[0].p[j] = PW'(j + 1);
        tbl[0].exp_sum = 36;      tbl[0].exp_ovf = 0;
        for (int j = 0; j < N; j++) tbl[1].p[j] = 16'hFF01;
        tbl[1].exp_sum = -2040;   tbl[1].exp_ovf = 0;
        for (int j = 0; j < N; j++) tbl[2].p[j] = 16'h7FFF;
        tbl[2].exp_sum = 262136;  tbl[2].exp_ovf = 0;
        for (int j = 0; j < N; j++) tbl[3].p[j] = 16'h8000;
        tbl[3].exp_sum = -262144; tbl[3].exp_ovf = 0;
        for (int j = 0; j < N; j++) tbl[4].p[j] = (j % 2 == 0) ? 16'd1000 : 16'hFC18;
        tbl[4].exp_sum = 0;       tbl[4].exp_ovf = 0;
        for (int j = 0; j < N; j++) tbl[5].p[j] = PW'(-(j * 3));
        tbl[5].exp_sum = -84;     tbl[5].exp_ovf = 0;

        rst = 1; p_valid = 0; p_in = '0; clear = 0; sum_ready = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("reset_sum_out", longint'(sum_out), 0);
        check("reset_sum_valid", longint'(sum_valid), 0);
        check("reset_overflow", longint'(overflow), 0);
        check("reset_cnt", longint'(cnt), 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < N; j++) send(tbl[i].p[j], 1'b1);
            check("tbl_sum", longint'($signed(sum_out)), tbl[i].exp_sum);
            check("tbl_ovf", longint'(overflow), longint'(tbl[i].exp_ovf));
            check("tbl_valid", longint'(sum_valid), 1);
            cycle(1'b0, '0, 1'b1, 1'b0, a);
            check("tbl_valid_drop", longint'(sum_valid), 0);
        end

        // Backpressure: result held, upstream stalled, nothing lost.
        send_frame(16'd5, 1'b0);
        check("hold_sum", longint'($signed(sum_out)), 40);
        hold_acc = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 16'd3, 1'b0, 1'b0, a);
            if (a) hold_acc++;
            check("hold_stable", longint'($signed(sum_out)), 40);
            check("hold_ready", longint'(p_ready), 0);
        end
        check("hold_no_accept", longint'(hold_acc), 0);
        send_frame(16'd3, 1'b1);
        check("after_hold_sum", longint'($signed(sum_out)), 24);
        cycle(1'b0, '0, 1'b1, 1'b0, a);

        // Narrow accumulator overflow.
        send_frame(16'd16384, 1'b1);
        check("aw18_valid", longint'(sum_valid18), 1);
`ifdef ACC_SAT_EN
        check("aw18_sum", longint'($signed(sum_out18)), 131071);
`else
        check("aw18_sum", longint'($signed(sum_out18)), -131072);
`endif
        check("aw18_ovf", longint'(overflow18), 1);
        check("aw24_sum", longint'($signed(sum_out)), 131072);
        cycle(1'b0, '0, 1'b1, 1'b0, a);

        // Clear mid-frame discards partial sum and the coincident product.
        for (int k = 0; k < 3; k++) send(16'd100, 1'b1);
        check("pre_clear_cnt", longint'(cnt), 3);
        cycle(1'b1, 16'd100, 1'b1, 1'b1, a);
        check("clear_cnt", longint'(cnt), 0);
        send_frame(16'd2, 1'b1);
        check("clear_sum", longint'($signed(sum_out)), 16);
        cycle(1'b0, '0, 1'b1, 1'b0, a);

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 5; k++) send(16'd7, 1'b1);
        #2 rst = 1;
        #1;
        model_reset();
        check("rst_cnt", longint'(cnt), 0);
        check("rst_sum_out", longint'(sum_out), 0);
        check("rst_sum_valid", longint'(sum_valid), 0);
        check("rst_overflow", longint'(overflow), 0);
        @(negedge clk);
        check_outputs();
        rst = 0;
        send_frame(16'd1, 1'b1);
        check("post_rst_sum", longint'($signed(sum_out)), 8);
        cycle(1'b0, '0, 1'b1, 1'b0, a);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, PW'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 40) == 0, a);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Signed accumulation stage directly downstream of the combinational 8x8 signed multiplier. It consumes the multiplier's 16-bit two's-complement product through a valid/ready handshake and sums N consecutive products into one frame result. The result is presented on a valid/ready output port with a per-frame overflow flag. This turns the multiplier into a dot-product / MAC datapath.

## Interface
- PW, 16: product width in bits; equals the multiplier output width.
- AW, 24: accumulator and result width in bits; must be ≥ PW.
- N, 8: number of products per frame; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- p_in  in  PW  signed product from the multiplier.
- p_valid  in  1  p_in is valid this cycle.
- p_ready  out  1  stage accepts p_in this cycle.
- clear  in  1  synchronous frame abort.
- sum_out  out  AW  signed frame result.
- sum_valid  out  1  sum_out is valid.
- sum_ready  in  1  downstream accepts sum_out.
- overflow  out  1  signed overflow occurred in the presented frame.
- cnt  out  $clog2(N)  number of products accepted in the current frame.

## Operation
- Two states:
  - ACCUM: collecting products.
  - HOLD: result presented.
- A product is accepted when p_valid && p_ready.
- p_ready = (state==ACCUM) || (state==HOLD && sum_ready). The ready path is combinational from sum_ready; p_ready does not depend on p_valid.
- ACCUM behaviour:
  - Each accepted product is sign-extended to AW and added to acc; cnt increments.
  - An overflow-sticky bit sets on any signed overflow of the addition.
- On acceptance of the Nth product (cnt==N-1):
  - sum_out <= acc + p_in (overflow-handled per Configuration).
  - overflow <= sticky OR this-add overflow.
  - sum_valid <= 1; acc, cnt and sticky reset to 0; state -> HOLD.
- HOLD behaviour:
  - sum_out and overflow are held stable while sum_valid && !sum_ready.
  - On sum_ready, sum_valid drops and the state returns to ACCUM.
  - If a product is accepted in the same cycle as sum_ready, it becomes product 1 of the next frame: acc = that product, cnt = 1.
- clear has priority over all other inputs:
  - state -> ACCUM; acc, cnt, sticky, sum_valid and overflow -> 0.
  - A product presented in the same cycle is discarded.
- Reset values: state ACCUM, sum_out 0, sum_valid 0, overflow 0, cnt 0, acc 0.
- Asynchronous reset mid-frame discards all partial work.

## Timing
- sum_valid rises on the clock edge that accepts the Nth product, i.e. one cycle of registered latency.
- Minimum frame period is N cycles: back-to-back frames are possible when sum_ready is held high.
- cnt, sum_out, sum_valid and overflow are registered outputs.
- p_ready is combinational.

## Configuration
- ACC_SAT_EN defined:
  - On signed overflow, the result saturates to 2^(AW-1)-1 (positive overflow) or -2^(AW-1) (negative overflow).
  - The intermediate acc also saturates.
  - overflow is still reported.
- ACC_SAT_EN undefined:
  - Arithmetic wraps modulo 2^AW.
  - overflow reports that wrapping occurred.

## Structure
- acc_pkg contains:
  - state enum (ACCUM, HOLD);
  - sign-extend helper function;
  - saturation-limit constants derived from AW.
- Sub-module acc_sat_add: AW-bit signed adder that outputs the sum and an overflow bit, with saturation compiled in under ACC_SAT_EN.

## Test plan
- Products 1,2,…,8, sum_ready=1 → sum_out=36, sum_valid for 1 cycle, overflow=0.
- Eight products of 16'hFF01 (-255) → sum_out=24'hFFF808 (-2040).
- Complete a frame, then hold sum_ready low 5 cycles → sum_out stable, p_ready=0, no products lost; then 8 products of 3 with sum_ready=1 → 24.
- Assert clear after 3 products of 100, then send 8 products of 2 → sum_out=16, cnt restarts at 0.
- AW=18, eight products of 16384:
  - without ACC_SAT_EN → sum_out=-131072, overflow=1;
  - with ACC_SAT_EN → sum_out=131071, overflow=1.
- Assert rst after 5 products of 7, then send 8 products of 1 → sum_out=8; all outputs 0 during reset.
